// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light sequencer.
// This package holds the FSM state encoding and the default array geometry.
package f1_pkg;

  localparam int N_LIGHTS_DEF = 8;
  localparam int RND_W_DEF    = 7;

  localparam logic [N_LIGHTS_DEF-1:0] ALL_ON = {N_LIGHTS_DEF{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Count value loaded into the hold counter. A random value of zero is
  // clamped to one, so the lights always stay on for at least one tick.
  function automatic logic [RND_W_DEF-1:0] clamp_hold(input logic [RND_W_DEF-1:0] v);
    logic [RND_W_DEF-1:0] r;
    if (v == {RND_W_DEF{1'b0}}) begin
      r = {{(RND_W_DEF-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/f1_light_seq_hold_counter.sv
// This counter runs the all-lights-on countdown. It loads the captured random
// value, with zero mapped to one, and then counts down to one without wrapping.
module hold_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         last
);

  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO = {W{1'b0}};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count value: load wins over decrement; the count stops at one.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      if (load_val == ZERO) begin
        cnt_d = ONE;
      end else begin
        cnt_d = load_val;
      end
    end else if (dec && (cnt_q > ONE)) begin
      cnt_d = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == ONE);

endmodule

// File: rtl/f1_light_seq.sv
// F1 start-light sequencer. On a trigger it lights the lamps one per tick, then
// holds all of them on for a random number of ticks and switches them off.
module f1_light_seq
  import f1_pkg::*;
#(
  parameter int N_LIGHTS = N_LIGHTS_DEF,
  parameter int RND_W    = RND_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger,
  input  logic                tick,
  input  logic [RND_W-1:0]    rnd,
  output logic                lfsr_en,
  output logic [N_LIGHTS-1:0] data_out,
  output logic                busy,
  output logic                done
);

  localparam logic [N_LIGHTS-1:0] ALL_ON_L  = {N_LIGHTS{1'b1}};
  localparam logic [N_LIGHTS-1:0] ALL_OFF_L = {N_LIGHTS{1'b0}};
  localparam logic [RND_W-1:0]    CNT_ZERO  = {RND_W{1'b0}};

  state_e              state_q, state_d;
  logic [N_LIGHTS-1:0] data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                lfsr_en_q, lfsr_en_d;

  logic                load_s;
  logic                dec_s;
  logic [RND_W-1:0]    cnt_s;
  logic                cnt_last_s;

  hold_counter #(
    .W (RND_W)
  ) u_hold_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (rnd),
    .dec      (dec_s),
    .cnt      (cnt_s),
    .last     (cnt_last_s)
  );

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    done_d  = 1'b0;
    load_s  = 1'b0;
    dec_s   = 1'b0;

    case (state_q)
      IDLE: begin
        data_d = ALL_OFF_L;
        if (trigger) begin
          state_d = BUILD;
        end else begin
          state_d = IDLE;
        end
      end

      BUILD: begin
        if (tick) begin
          if (data_q == ALL_ON_L) begin
            load_s  = 1'b1;
            state_d = HOLD;
          end else begin
            data_d = {data_q[N_LIGHTS-2:0], 1'b1};
          end
        end else begin
          state_d = BUILD;
        end
      end

      HOLD: begin
        data_d = ALL_ON_L;
        if (tick) begin
          // A zero count can only come from a corrupted counter. In that case
          // the sequence ends instead of waiting for a wrap.
          if (cnt_last_s || (cnt_s == CNT_ZERO)) begin
            data_d  = ALL_OFF_L;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            dec_s = 1'b1;
          end
        end else begin
          state_d = HOLD;
        end
      end

      default: begin
        state_d = IDLE;
        data_d  = ALL_OFF_L;
      end
    endcase

    busy_d    = (state_d != IDLE);
    lfsr_en_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= ALL_OFF_L;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lfsr_en_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lfsr_en_q <= lfsr_en_d;
    end
  end

  assign data_out = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign lfsr_en  = lfsr_en_q;

endmodule
